// File: rtl/matmul_tile_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : matmul_tile_scheduler_pkg                                  |
// | Description : Shared types and constants for the matmul tile scheduler:  |
// |               FSM state encoding, element size in bytes and the width of |
// |               the tile size fields.                                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package matmul_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Every matrix element occupies one 64-bit memory word.
  localparam int ELEM_BYTES = 8;

  // Width needed to hold a tile edge length in the range 0..m.
  function automatic int size_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_tile_scheduler_tile_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matmul_tile_scheduler_tile_addr_gen                        |
// | Description : Combinational tile_addr_gen. Maps tile indices (ti,tj,tk)  |
// |               and the latched job configuration to A/W/C sub-block byte  |
// |               addresses, edge-trimmed tile sizes, the accumulate flag    |
// |               and per-dimension "last tile" flags.                       |
// | Ports       : i_ti/i_tj/i_tk   tile indices                              |
// |               i_k1/i_k2/i_k3   matrix dimensions                         |
// |               i_*_base         byte base addresses                       |
// |               o_*_addr         sub-block byte addresses (wrap mod 2^AW)  |
// |               o_rows/cols/depth, o_accumulate, o_last_*                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module matmul_tile_scheduler_tile_addr_gen
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int M          = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic [DIM_WIDTH-1:0]     i_ti,
  input  logic [DIM_WIDTH-1:0]     i_tj,
  input  logic [DIM_WIDTH-1:0]     i_tk,
  input  logic [DIM_WIDTH-1:0]     i_k1,
  input  logic [DIM_WIDTH-1:0]     i_k2,
  input  logic [DIM_WIDTH-1:0]     i_k3,
  input  logic [ADDR_WIDTH-1:0]    i_a_base,
  input  logic [ADDR_WIDTH-1:0]    i_w_base,
  input  logic [ADDR_WIDTH-1:0]    i_c_base,
  output logic [ADDR_WIDTH-1:0]    o_a_addr,
  output logic [ADDR_WIDTH-1:0]    o_w_addr,
  output logic [ADDR_WIDTH-1:0]    o_c_addr,
  output logic [size_width(M)-1:0] o_rows,
  output logic [size_width(M)-1:0] o_cols,
  output logic [size_width(M)-1:0] o_depth,
  output logic                     o_accumulate,
  output logic                     o_last_row,
  output logic                     o_last_col,
  output logic                     o_last_dep
);

  localparam int c_SIZE_W = size_width(M);
  // Remainder width: large enough that idx*M never overflows for any valid index.
  localparam int c_RW     = DIM_WIDTH + c_SIZE_W + 1;

  localparam logic [ADDR_WIDTH-1:0] c_M_A    = ADDR_WIDTH'(M);
  localparam logic [ADDR_WIDTH-1:0] c_ELEM_A = ADDR_WIDTH'(ELEM_BYTES);
  localparam logic [c_RW-1:0]       c_M_R    = c_RW'(M);

  // Address arithmetic is done directly at ADDR_WIDTH: results wrap modulo
  // 2^ADDR_WIDTH, so truncating the operands first gives the same answer.
  logic [ADDR_WIDTH-1:0] w_row0_a;
  logic [ADDR_WIDTH-1:0] w_col0_a;
  logic [ADDR_WIDTH-1:0] w_dep0_a;

  assign w_row0_a = ADDR_WIDTH'(i_ti) * c_M_A;
  assign w_col0_a = ADDR_WIDTH'(i_tj) * c_M_A;
  assign w_dep0_a = ADDR_WIDTH'(i_tk) * c_M_A;

  assign o_a_addr = i_a_base + (w_row0_a * ADDR_WIDTH'(i_k2) + w_dep0_a) * c_ELEM_A;
  assign o_w_addr = i_w_base + (w_dep0_a * ADDR_WIDTH'(i_k3) + w_col0_a) * c_ELEM_A;
  assign o_c_addr = i_c_base + (w_row0_a * ADDR_WIDTH'(i_k3) + w_col0_a) * c_ELEM_A;

  // Elements remaining from this tile's origin to the matrix edge.
  logic [c_RW-1:0] w_rows_rem;
  logic [c_RW-1:0] w_cols_rem;
  logic [c_RW-1:0] w_dep_rem;

  assign w_rows_rem = c_RW'(i_k1) - c_RW'(i_ti) * c_M_R;
  assign w_cols_rem = c_RW'(i_k3) - c_RW'(i_tj) * c_M_R;
  assign w_dep_rem  = c_RW'(i_k2) - c_RW'(i_tk) * c_M_R;

  assign o_rows  = (w_rows_rem >= c_M_R) ? c_SIZE_W'(M) : c_SIZE_W'(w_rows_rem);
  assign o_cols  = (w_cols_rem >= c_M_R) ? c_SIZE_W'(M) : c_SIZE_W'(w_cols_rem);
  assign o_depth = (w_dep_rem  >= c_M_R) ? c_SIZE_W'(M) : c_SIZE_W'(w_dep_rem);

  // A tile is the last along a dimension when no more than M elements remain.
  assign o_last_row = (w_rows_rem <= c_M_R);
  assign o_last_col = (w_cols_rem <= c_M_R);
  assign o_last_dep = (w_dep_rem  <= c_M_R);

  assign o_accumulate = (i_tk != '0);

endmodule
`default_nettype wire

// File: rtl/matmul_tile_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matmul_tile_scheduler                                      |
// | Description : Splits a K1xK2 * K2xK3 matrix multiply into MxM tile jobs  |
// |               and issues them one at a time to the tile engine using a   |
// |               tile_start / tile_done handshake. Loop order ti, tj, tk.   |
// | Ports       : clk, reset_n (async active-low)                            |
// |               start/busy/done/cfg_err      host job interface           |
// |               K1/K2/K3, *_base_addr        job configuration            |
// |               tile_start/tile_done         tile engine handshake        |
// |               tile_*_addr, tile_rows/cols/depth, tile_accumulate         |
// |               ld_a/ld_w/ld_c               row strides in elements      |
// |               perf_cycles/perf_tiles       only with TILE_SCHED_PERF_EN |
// | Config      : `define TILE_SCHED_PERF_EN adds per-job performance        |
// |               counters (busy cycles, tiles issued).                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int M          = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [DIM_WIDTH-1:0]     K1,
  input  logic [DIM_WIDTH-1:0]     K2,
  input  logic [DIM_WIDTH-1:0]     K3,
  input  logic [ADDR_WIDTH-1:0]    A_base_addr,
  input  logic [ADDR_WIDTH-1:0]    W_base_addr,
  input  logic [ADDR_WIDTH-1:0]    C_base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     tile_start,
  input  logic                     tile_done,
  output logic [ADDR_WIDTH-1:0]    tile_A_addr,
  output logic [ADDR_WIDTH-1:0]    tile_W_addr,
  output logic [ADDR_WIDTH-1:0]    tile_C_addr,
  output logic [size_width(M)-1:0] tile_rows,
  output logic [size_width(M)-1:0] tile_cols,
  output logic [size_width(M)-1:0] tile_depth,
  output logic                     tile_accumulate,
  output logic [DIM_WIDTH-1:0]     ld_a,
  output logic [DIM_WIDTH-1:0]     ld_w,
`ifdef TILE_SCHED_PERF_EN
  output logic [31:0]              perf_cycles,
  output logic [15:0]              perf_tiles,
`endif
  output logic [DIM_WIDTH-1:0]     ld_c
);

  state_t r_state;
  state_t w_state_next;

  logic [DIM_WIDTH-1:0]  r_k1, r_k2, r_k3;
  logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_c_base;
  logic [DIM_WIDTH-1:0]  r_ti, r_tj, r_tk;
  logic                  r_cfg_err;

  logic w_accept;
  logic w_cfg_zero;
  logic w_last_row, w_last_col, w_last_dep;
  logic w_last_tile;

  // busy is low in IDLE, so an IDLE-state start is always an accepted one.
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_cfg_zero  = (r_k1 == '0) || (r_k2 == '0) || (r_k3 == '0);
  assign w_last_tile = w_last_row && w_last_col && w_last_dep;

  // Tile fields are derived from registered indices and the latched config,
  // so they stay stable throughout WAIT and read 0 right after reset.
  matmul_tile_scheduler_tile_addr_gen #(
    .M          (M),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_tile_addr_gen (
    .i_ti         (r_ti),
    .i_tj         (r_tj),
    .i_tk         (r_tk),
    .i_k1         (r_k1),
    .i_k2         (r_k2),
    .i_k3         (r_k3),
    .i_a_base     (r_a_base),
    .i_w_base     (r_w_base),
    .i_c_base     (r_c_base),
    .o_a_addr     (tile_A_addr),
    .o_w_addr     (tile_W_addr),
    .o_c_addr     (tile_C_addr),
    .o_rows       (tile_rows),
    .o_cols       (tile_cols),
    .o_depth      (tile_depth),
    .o_accumulate (tile_accumulate),
    .o_last_row   (w_last_row),
    .o_last_col   (w_last_col),
    .o_last_dep   (w_last_dep)
  );

  assign ld_a    = r_k2;
  assign ld_w    = r_k3;
  assign ld_c    = r_k3;
  assign cfg_err = r_cfg_err;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    tile_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        busy         = 1'b1;
        w_state_next = w_cfg_zero ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy         = 1'b1;
        tile_start   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (tile_done) w_state_next = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        busy         = 1'b1;
        w_state_next = w_last_tile ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Config latch, error flag and tile index counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k1      <= '0;
      r_k2      <= '0;
      r_k3      <= '0;
      r_a_base  <= '0;
      r_w_base  <= '0;
      r_c_base  <= '0;
      r_ti      <= '0;
      r_tj      <= '0;
      r_tk      <= '0;
      r_cfg_err <= 1'b0;
    end else if (w_accept) begin
      r_k1      <= K1;
      r_k2      <= K2;
      r_k3      <= K3;
      r_a_base  <= A_base_addr;
      r_w_base  <= W_base_addr;
      r_c_base  <= C_base_addr;
      r_ti      <= '0;
      r_tj      <= '0;
      r_tk      <= '0;
      r_cfg_err <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_cfg_err <= w_cfg_zero;
    end else if (r_state == ST_ADVANCE) begin
      // tk innermost, then tj, then ti; all wrap to 0 after the final tile.
      if (!w_last_dep) begin
        r_tk <= r_tk + DIM_WIDTH'(1);
      end else begin
        r_tk <= '0;
        if (!w_last_col) begin
          r_tj <= r_tj + DIM_WIDTH'(1);
        end else begin
          r_tj <= '0;
          if (!w_last_row) r_ti <= r_ti + DIM_WIDTH'(1);
          else             r_ti <= '0;
        end
      end
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_tiles;

  // Saturating per-job counters; they hold their final value after done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (tile_start && (r_perf_tiles != '1)) r_perf_tiles <= r_perf_tiles + 16'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_tiles  = r_perf_tiles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_tile_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_matmul_tile_scheduler                                   |
// | Description : Scoreboard bench for matmul_tile_scheduler (M=3). Jobs     |
// |               push hand-computed tile and completion records; a monitor  |
// |               pops and compares them whenever tile_start or done appear. |
// |               A tile engine model answers tile_done 5 cycles after each  |
// |               tile_start. Perf counters checked with TILE_SCHED_PERF_EN. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_matmul_tile_scheduler;

  localparam int M  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b0;
  logic          start       = 1'b0;
  logic          tile_done   = 1'b0;
  logic [DW-1:0] K1 = '0, K2 = '0, K3 = '0;
  logic [AW-1:0] A_base_addr = '0, W_base_addr = '0, C_base_addr = '0;

  logic          busy, done, cfg_err, tile_start, tile_accumulate;
  logic [AW-1:0] tile_A_addr, tile_W_addr, tile_C_addr;
  logic [1:0]    tile_rows, tile_cols, tile_depth;
  logic [DW-1:0] ld_a, ld_w, ld_c;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_tiles;
`endif

  matmul_tile_scheduler #(.M(M), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .K1              (K1),
    .K2              (K2),
    .K3              (K3),
    .A_base_addr     (A_base_addr),
    .W_base_addr     (W_base_addr),
    .C_base_addr     (C_base_addr),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .tile_start      (tile_start),
    .tile_done       (tile_done),
    .tile_A_addr     (tile_A_addr),
    .tile_W_addr     (tile_W_addr),
    .tile_C_addr     (tile_C_addr),
    .tile_rows       (tile_rows),
    .tile_cols       (tile_cols),
    .tile_depth      (tile_depth),
    .tile_accumulate (tile_accumulate),
    .ld_a            (ld_a),
    .ld_w            (ld_w),
`ifdef TILE_SCHED_PERF_EN
    .perf_cycles     (perf_cycles),
    .perf_tiles      (perf_tiles),
`endif
    .ld_c            (ld_c)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int w; int c; int r; int co; int d; int acc; } tile_t;
  typedef struct { int err; int tiles; } job_t;

  tile_t exp_tiles[$];
  job_t  exp_jobs[$];

  int total = 0, bad = 0;
  int cyc = 0, last_trig = 0, rst_gen = 0;
  int busy_cnt = 0, tiles_seen = 0;
  int exp_lda = 0, exp_ldw = 0;
  int in_tile = 0;
  int hold_a = 0, hold_c = 0, hold_r = 0;
  tile_t mon_t;
  job_t  mon_j;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (reset_n) begin
      if (tile_start) begin
        tiles_seen++;
        chk("tile_latency", 64'(cyc - last_trig), 2);
        chk("tile_busy", busy, 1);
        chk("tile_cfg_err", cfg_err, 0);
        chk("tile_expected", exp_tiles.size() != 0, 1);
        if (exp_tiles.size() != 0) begin
          mon_t = exp_tiles.pop_front();
          chk("tile_A_addr", tile_A_addr, mon_t.a);
          chk("tile_W_addr", tile_W_addr, mon_t.w);
          chk("tile_C_addr", tile_C_addr, mon_t.c);
          chk("tile_rows", tile_rows, mon_t.r);
          chk("tile_cols", tile_cols, mon_t.co);
          chk("tile_depth", tile_depth, mon_t.d);
          chk("tile_accumulate", tile_accumulate, mon_t.acc);
        end
        chk("ld_a", ld_a, exp_lda);
        chk("ld_w", ld_w, exp_ldw);
        chk("ld_c", ld_c, exp_ldw);
        hold_a  = int'(tile_A_addr);
        hold_c  = int'(tile_C_addr);
        hold_r  = int'(tile_rows);
        in_tile = 1;
      end else if (busy && in_tile != 0) begin
        chk("hold_A_addr", tile_A_addr, hold_a);
        chk("hold_C_addr", tile_C_addr, hold_c);
        chk("hold_rows", tile_rows, hold_r);
      end
      if (done) begin
        in_tile = 0;
        chk("done_latency", 64'(cyc - last_trig), 2);
        chk("done_busy", busy, 0);
        chk("done_expected", exp_jobs.size() != 0, 1);
        if (exp_jobs.size() != 0) begin
          mon_j = exp_jobs.pop_front();
          chk("done_cfg_err", cfg_err, mon_j.err);
          chk("tiles_issued", tiles_seen, mon_j.tiles);
`ifdef TILE_SCHED_PERF_EN
          chk("perf_tiles", perf_tiles, mon_j.tiles);
          chk("perf_cycles", perf_cycles, busy_cnt);
`endif
        end
      end
    end
  end

  // ---------------- tile engine model ----------------
  initial begin
    forever begin
      automatic int g;
      @(negedge clk);
      if (tile_start && reset_n) begin
        g = rst_gen;
        repeat (5) @(negedge clk);
        if (g == rst_gen) begin
          tile_done = 1'b1;
          last_trig = cyc;
          @(negedge clk);
          tile_done = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pt(input int a, w, c, r, co, d, acc);
    exp_tiles.push_back('{a, w, c, r, co, d, acc});
  endtask

  task automatic issue_job(input int k1, k2, k3, input int err, input int ntiles);
    @(negedge clk);
    K1 = DW'(k1); K2 = DW'(k2); K3 = DW'(k3);
    A_base_addr = 16'd0; W_base_addr = 16'd512; C_base_addr = 16'd1024;
    exp_lda = k2; exp_ldw = k3;
    exp_jobs.push_back('{err, ntiles});
    busy_cnt = 0; tiles_seen = 0;
    start = 1'b1;
    last_trig = cyc;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the job must run on its latched copy.
    K1 = 8'hFF; K2 = 8'hFF; K3 = 8'hFF;
    A_base_addr = 16'hFFFF; W_base_addr = 16'hFFFF; C_base_addr = 16'hFFFF;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic wait_tile_start();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = tile_start;
    end
    chk("tile_start_seen", seen, 1);
  endtask

  task automatic push_case3();
    pt(  0, 512, 1024, 3, 2, 3, 0);
    pt( 24, 560, 1024, 3, 2, 2, 1);
    pt(120, 512, 1072, 1, 2, 3, 0);
    pt(144, 560, 1072, 1, 2, 2, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_tile_start", tile_start, 0);
    chk("rst_tile_A_addr", tile_A_addr, 0);
    chk("rst_tile_rows", tile_rows, 0);
    chk("rst_ld_a", ld_a, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 3x3x3 tile
    pt(0, 512, 1024, 3, 3, 3, 0);
    issue_job(3, 3, 3, 0, 1);
    wait_done();

    // 6x6x6: eight full tiles; a stray start during WAIT must be ignored
    pt(  0, 512, 1024, 3, 3, 3, 0);
    pt( 24, 656, 1024, 3, 3, 3, 1);
    pt(  0, 536, 1048, 3, 3, 3, 0);
    pt( 24, 680, 1048, 3, 3, 3, 1);
    pt(144, 512, 1168, 3, 3, 3, 0);
    pt(168, 656, 1168, 3, 3, 3, 1);
    pt(144, 536, 1192, 3, 3, 3, 0);
    pt(168, 680, 1192, 3, 3, 3, 1);
    issue_job(6, 6, 6, 0, 8);
    wait_tile_start();
    repeat (2) @(negedge clk);
    K1 = 8'd3; K2 = 8'd3; K3 = 8'd3; A_base_addr = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Ragged edges: K1=4, K2=5, K3=2
    push_case3();
    issue_job(4, 5, 2, 0, 4);
    wait_done();

    // Zero dimension: error, no tiles
    issue_job(3, 0, 3, 1, 0);
    wait_done();
    chk("cfg_err_held", cfg_err, 1);

    // Asynchronous reset in the middle of WAIT
    pt(0, 512, 1024, 3, 3, 3, 0);
    issue_job(3, 3, 3, 0, 1);
    wait_tile_start();
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    rst_gen++;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tile_start", tile_start, 0);
    chk("arst_tile_A_addr", tile_A_addr, 0);
    chk("arst_tile_W_addr", tile_W_addr, 0);
    chk("arst_tile_C_addr", tile_C_addr, 0);
    chk("arst_tile_rows", tile_rows, 0);
    chk("arst_cfg_err", cfg_err, 0);
    exp_tiles.delete();
    exp_jobs.delete();
    in_tile = 0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal job after reset
    push_case3();
    issue_job(4, 5, 2, 0, 4);
    wait_done();

    chk("tiles_left", exp_tiles.size(), 0);
    chk("jobs_left", exp_jobs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
